// File: rtl/rf_pkg.sv
// Shared types and helpers for the 2-read/1-write byte-enabled register file.
// The byte merge is sized for the widest supported word; callers extend and truncate.
package rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_MAX_W  = 256;
  localparam int RF_MAX_BW = RF_MAX_W / 8;

  // Replace each byte of old_w with the matching byte of new_w where be is set.
  function automatic logic [RF_MAX_W-1:0] rf_merge(
    input logic [RF_MAX_W-1:0]  old_w,
    input logic [RF_MAX_W-1:0]  new_w,
    input logic [RF_MAX_BW-1:0] be
  );
    logic [RF_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < RF_MAX_BW; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks every entry once, one per cycle, then pulses done.
// Busy covers exactly DEPTH cycles; done is registered alongside the return to IDLE.
module rf_clear_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start_i,
  output logic          busy_o,
  output logic          clr_done_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);
  import rf_pkg::*;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    clr_we_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we_o = 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_done_o = done_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/rf_2r1w_be.sv
// Register file with one byte-enabled write port and two registered read ports.
// Reads bypass a same-cycle write to the same entry (write-first); out-of-range reads return 0.
module rf_2r1w_be #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BW-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd0_en,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic             rd0_valid,
  input  logic             rd1_en,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_valid,
  input  logic             clr_start,
  output logic             busy,
  output logic             clr_done
);
  import rf_pkg::*;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                clr_we;
  logic [AW-1:0]       clr_addr;
  logic                wr_in_range;
  logic                wr_acc;
  logic [WIDTH-1:0]    wr_old;
  logic [RF_MAX_W-1:0] merged_ext;
  logic [WIDTH-1:0]    wr_merged;

  rf_clear_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_start_i(clr_start),
    .busy_o     (busy),
    .clr_done_o (clr_done),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // A clear request in IDLE wins over a write presented in the same cycle.
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign wr_acc      = wr_en & ~busy & ~clr_start & wr_in_range;
  assign wr_old      = wr_in_range ? mem_q[wr_addr] : '0;
  assign merged_ext  = rf_merge(RF_MAX_W'(wr_old), RF_MAX_W'(wr_data), RF_MAX_BW'(wr_be));
  assign wr_merged   = merged_ext[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_addr] <= wr_merged;
    end
  end

  logic          rd_en   [2];
  logic [AW-1:0] rd_addr [2];

  assign rd_en[0]   = rd0_en;
  assign rd_en[1]   = rd1_en;
  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic             in_range;
    logic             acc;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_comb begin
      in_range = ({1'b0, rd_addr[gi]} < DEPTH_C);
      acc      = rd_en[gi] & ~busy;
      word     = '0;
      if (in_range) begin
        word = (wr_acc && (wr_addr == rd_addr[gi])) ? wr_merged : mem_q[rd_addr[gi]];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= acc;
        if (acc) data_q <= word;
      end
    end
  end

  assign rd0_data  = g_rd[0].data_q;
  assign rd0_valid = g_rd[0].valid_q;
  assign rd1_data  = g_rd[1].data_q;
  assign rd1_valid = g_rd[1].valid_q;

endmodule

// File: tb/tb_rf_2r1w_be.sv
// Scoreboard bench for rf_2r1w_be: an 8-entry instance plus a 6-entry instance for range checks.
// Stimulus pushes hand-computed expectations; one negedge monitor pops and compares them.
module tb_rf_2r1w_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        wr_en, rd0_en, rd1_en, clr_start;
  logic [2:0]  wr_addr, rd0_addr, rd1_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data, rd0_data, rd1_data;
  logic        rd0_valid, rd1_valid, busy, clr_done;

  logic        s_wr_en, s_rd0_en, s_rd1_en, s_clr_start;
  logic [2:0]  s_wr_addr, s_rd0_addr, s_rd1_addr;
  logic [1:0]  s_wr_be;
  logic [15:0] s_wr_data, s_rd0_data, s_rd1_data;
  logic        s_rd0_valid, s_rd1_valid, s_busy, s_clr_done;

  rf_2r1w_be #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
  );

  rf_2r1w_be #(.WIDTH(16), .DEPTH(6)) dut_s (
    .clk(clk), .rst(rst),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_be(s_wr_be), .wr_data(s_wr_data),
    .rd0_en(s_rd0_en), .rd0_addr(s_rd0_addr), .rd0_data(s_rd0_data), .rd0_valid(s_rd0_valid),
    .rd1_en(s_rd1_en), .rd1_addr(s_rd1_addr), .rd1_data(s_rd1_data), .rd1_valid(s_rd1_valid),
    .clr_start(s_clr_start), .busy(s_busy), .clr_done(s_clr_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int due; logic [15:0] data; } rd_exp_t;
  typedef struct { int due; int kind; logic [15:0] exp; } st_exp_t;

  rd_exp_t q0[$], q1[$], q2[$], q3[$];
  st_exp_t sq[$];

  int n_vec = 0;
  int n_bad = 0;
  bit end_req = 1'b0;

  function automatic void cmp(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endfunction

  // Each read response is due exactly one edge after issue; any other valid is unexpected.
  always @(negedge clk) begin
    logic        want;
    logic [15:0] e;

    want = (q0.size() != 0) && (q0[0].due == cyc);
    e = want ? q0[0].data : 16'h0;
    if (want || rd0_valid) cmp("rd0 valid/data", {rd0_valid, want ? rd0_data : 16'h0}, {want, e});
    if (want) q0.delete(0);

    want = (q1.size() != 0) && (q1[0].due == cyc);
    e = want ? q1[0].data : 16'h0;
    if (want || rd1_valid) cmp("rd1 valid/data", {rd1_valid, want ? rd1_data : 16'h0}, {want, e});
    if (want) q1.delete(0);

    want = (q2.size() != 0) && (q2[0].due == cyc);
    e = want ? q2[0].data : 16'h0;
    if (want || s_rd0_valid) cmp("d6 rd0 valid/data", {s_rd0_valid, want ? s_rd0_data : 16'h0}, {want, e});
    if (want) q2.delete(0);

    want = (q3.size() != 0) && (q3[0].due == cyc);
    e = want ? q3[0].data : 16'h0;
    if (want || s_rd1_valid) cmp("d6 rd1 valid/data", {s_rd1_valid, want ? s_rd1_data : 16'h0}, {want, e});
    if (want) q3.delete(0);

    for (int i = sq.size() - 1; i >= 0; i--) begin
      if (sq[i].due == cyc) begin
        case (sq[i].kind)
          0:       cmp("busy",     {16'h0, busy},     {1'b0, sq[i].exp});
          1:       cmp("clr_done", {16'h0, clr_done}, {1'b0, sq[i].exp});
          2:       cmp("rd0_data", {1'b0, rd0_data},  {1'b0, sq[i].exp});
          default: cmp("rd1_data", {1'b0, rd1_data},  {1'b0, sq[i].exp});
        endcase
        sq.delete(i);
      end
    end

    if (end_req) begin
      cmp("unserved expectations", 17'(q0.size() + q1.size() + q2.size() + q3.size() + sq.size()), 17'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic idle_inputs();
    wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0; clr_start = 1'b0;
    s_wr_en = 1'b0; s_rd0_en = 1'b0; s_rd1_en = 1'b0; s_clr_start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] be, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
  endtask

  task automatic s_wr(input logic [2:0] a, input logic [1:0] be, input logic [15:0] d);
    s_wr_en = 1'b1; s_wr_addr = a; s_wr_be = be; s_wr_data = d;
  endtask

  task automatic rd(input int port, input logic [2:0] a, input logic [15:0] d);
    rd_exp_t x;
    x.due = cyc + 1;
    x.data = d;
    case (port)
      0: begin rd0_en = 1'b1; rd0_addr = a; q0.push_back(x); end
      1: begin rd1_en = 1'b1; rd1_addr = a; q1.push_back(x); end
      2: begin s_rd0_en = 1'b1; s_rd0_addr = a; q2.push_back(x); end
      default: begin s_rd1_en = 1'b1; s_rd1_addr = a; q3.push_back(x); end
    endcase
  endtask

  task automatic expect_st(input int kind, input int dly, input logic [15:0] e);
    st_exp_t x;
    x.due = cyc + dly;
    x.kind = kind;
    x.exp = e;
    sq.push_back(x);
  endtask

  task automatic clear_timing_checks();
    expect_st(0, 0, 16'h0);
    expect_st(0, 1, 16'h1);
    expect_st(0, 8, 16'h1);
    expect_st(0, 9, 16'h0);
    expect_st(1, 8, 16'h0);
    expect_st(1, 9, 16'h1);
    expect_st(1, 10, 16'h0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    wr_addr = '0; wr_be = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
    s_wr_addr = '0; s_wr_be = '0; s_wr_data = '0; s_rd0_addr = '0; s_rd1_addr = '0;
    idle_inputs();
    #1 rst = 1'b0;

    // Reset state
    @(posedge clk); #1;
    expect_st(0, 0, 16'h0);
    expect_st(1, 0, 16'h0);
    expect_st(2, 0, 16'h0);
    expect_st(3, 0, 16'h0);
    tick(); tick();
    rst = 1'b1;

    // Both ports read a freshly reset entry
    rd(0, 3'd3, 16'h0000); rd(1, 3'd3, 16'h0000); tick();

    // Full write then upper-byte-only write
    wr(3'd5, 2'b11, 16'hBEEF); tick();
    rd(0, 3'd5, 16'hBEEF); tick();
    wr(3'd5, 2'b10, 16'h1200); tick();
    rd(0, 3'd5, 16'h12EF); rd(1, 3'd5, 16'h12EF); tick();
    tick();
    expect_st(2, 0, 16'h12EF);

    // Same-cycle bypass on both ports, then a zero-enable write
    wr(3'd2, 2'b11, 16'h3C3C); tick();
    wr(3'd2, 2'b01, 16'hA5A5); rd(0, 3'd2, 16'h3CA5); rd(1, 3'd2, 16'h3CA5); tick();
    rd(0, 3'd2, 16'h3CA5); tick();
    wr(3'd2, 2'b00, 16'hFFFF); rd(1, 3'd2, 16'h3CA5); tick();
    rd(0, 3'd2, 16'h3CA5); tick();

    // 6-entry instance: out-of-range writes dropped, out-of-range reads return 0
    for (int i = 0; i < 6; i++) begin
      s_wr(3'(i), 2'b11, 16'(16'h0101 * (i + 1))); tick();
    end
    s_wr(3'd7, 2'b11, 16'h7777); tick();
    s_wr(3'd6, 2'b11, 16'h6666); tick();
    rd(2, 3'd7, 16'h0000); rd(3, 3'd6, 16'h0000); tick();
    for (int i = 0; i < 6; i++) begin
      rd(2, 3'(i), 16'(16'h0101 * (i + 1))); tick();
    end

    // Fill, then clear with a same-cycle write and read
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 2'b11, 16'(16'h1111 * (i + 1))); tick();
    end
    clr_start = 1'b1; wr(3'd0, 2'b11, 16'h9999); rd(0, 3'd4, 16'h5555);
    clear_timing_checks();
    expect_st(2, 4, 16'h5555);
    c = cyc;
    tick(); tick();
    wr(3'd1, 2'b11, 16'hFFFF); rd0_en = 1'b1; rd0_addr = 3'd1; rd1_en = 1'b1; rd1_addr = 3'd6;
    clr_start = 1'b1;
    tick();
    while (cyc < c + 10) tick();
    for (int i = 0; i < 8; i++) begin
      rd(0, 3'(i), 16'h0000); rd(1, 3'(7 - i), 16'h0000); tick();
    end

    // Reset in the middle of a clear
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 2'b11, 16'(16'h1010 * (i + 1))); tick();
    end
    clr_start = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    expect_st(0, 0, 16'h0);
    expect_st(1, 0, 16'h0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) expect_st(1, i, 16'h0);
    expect_st(0, 0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      rd(0, 3'(i), 16'h0000); rd(1, 3'(i), 16'h0000); tick();
    end

    // A fresh clear after the aborted one completes normally
    clr_start = 1'b1;
    clear_timing_checks();
    c = cyc;
    while (cyc < c + 12) tick();
    end_req = 1'b1;
  end

endmodule
